// File: rtl/prism_in_cond.sv
// Input conditioning for the PRISM input bus: two-flop synchroniser, per-bit
// programmable glitch filter, registered edge pulses, sticky edge flags and a maskable irq.
module prism_in_cond #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FILT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_raw,
  input  logic [WIDTH-1:0]     filt_en,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic [WIDTH-1:0]     irq_mask,
  input  logic [WIDTH-1:0]     flag_clr,
  output logic [WIDTH-1:0]     in_filt,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic [WIDTH-1:0]     edge_flag,
  output logic                 irq
);

  logic [WIDTH-1:0]                s1_q, s2_q;
  logic [WIDTH-1:0]                filt_q, filt_d;
  logic [WIDTH-1:0]                rise_q, rise_d;
  logic [WIDTH-1:0]                fall_q, fall_d;
  logic [WIDTH-1:0]                flag_q, flag_d;
  logic [WIDTH-1:0][FILT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]                upd;
  logic                            irq_q, irq_d;

  // Per-bit stability counter. The >= compare lets a shortened filt_len take
  // effect on a count already in flight.
  always_comb begin
    upd   = '0;
    cnt_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (filt_en[i]) begin
        if (s2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= filt_len) begin
          upd[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + FILT_BITS'(1);
        end
      end else begin
        upd[i] = s2_q[i] ^ filt_q[i];
      end
    end
  end

  always_comb begin
    filt_d = (filt_q & ~upd) | (s2_q & upd);
    rise_d = upd & s2_q;
    fall_d = upd & ~s2_q;
    // A new edge beats a simultaneous clear.
    flag_d = rise_d | fall_d | (flag_q & ~flag_clr);
    irq_d  = |(flag_d & irq_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      flag_q <= '0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      s1_q   <= in_raw;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
    end
  end

  assign in_filt   = filt_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign edge_flag = flag_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_prism_in_cond.sv
// Bench for prism_in_cond: directed steps from the test plan, then random traffic
// checked against a history-based model of the glitch filter.
module tb_prism_in_cond;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_raw, filt_en, irq_mask, flag_clr;
  logic [3:0] filt_len;
  logic [7:0] in_filt, rise, fall, edge_flag;
  logic       irq;

  int checks = 0;
  int errors = 0;

  prism_in_cond #(.WIDTH(8), .FILT_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_raw   (in_raw),
    .filt_en  (filt_en),
    .filt_len (filt_len),
    .irq_mask (irq_mask),
    .flag_clr (flag_clr),
    .in_filt  (in_filt),
    .rise     (rise),
    .fall     (fall),
    .edge_flag(edge_flag),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Model: a bit takes a new value once the synchronised input has shown that
  // value for filt_len+1 consecutive samples (or at once when unfiltered).
  logic [7:0] m_s1, m_s2, m_filt, m_rise, m_fall, m_flag;
  logic       m_irq;
  logic [7:0] hist[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_filt = '0; m_rise = '0; m_fall = '0; m_flag = '0;
    m_irq = 1'b0;
    hist.delete();
    repeat (16) hist.push_front(8'h00);
  endtask

  task automatic model_clock();
    logic [7:0] upd;
    logic [7:0] hv;
    logic       stable;
    hist.push_front(m_s2);
    if (hist.size() > 16) void'(hist.pop_back());
    upd = '0;
    for (int i = 0; i < 8; i++) begin
      if (!filt_en[i]) begin
        upd[i] = (m_s2[i] != m_filt[i]);
      end else begin
        stable = 1'b1;
        for (int k = 0; k <= int'(filt_len); k++) begin
          hv = hist[k];
          if (hv[i] == m_filt[i]) stable = 1'b0;
        end
        upd[i] = stable;
      end
    end
    m_rise = upd & m_s2;
    m_fall = upd & ~m_s2;
    m_flag = m_rise | m_fall | (m_flag & ~flag_clr);
    m_irq  = |(m_flag & irq_mask);
    m_filt = (m_filt & ~upd) | (m_s2 & upd);
    m_s2   = m_s1;
    m_s1   = in_raw;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_filt"}, in_filt, m_filt);
    check({tag, ".rise"}, rise, m_rise);
    check({tag, ".fall"}, fall, m_fall);
    check({tag, ".edge_flag"}, edge_flag, m_flag);
    check({tag, ".irq"}, {7'b0, irq}, {7'b0, m_irq});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_clock();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] flip;

    // Reset with all inputs high
    rst = 1'b1; in_raw = 8'hFF; filt_en = 8'hFF; filt_len = 4'd0;
    irq_mask = 8'h00; flag_clr = 8'h00;
    model_reset();
    #1;
    check("reset_async", in_filt, 8'h00);
    repeat (3) tick("reset");
    rst = 1'b0;
    tick("rel1");
    tick("rel2");
    tick("rel3");
    check("rel_in_filt", in_filt, 8'hFF);
    check("rel_rise", rise, 8'hFF);
    tick("rel4");
    check("rel_rise_gone", rise, 8'h00);

    // Filtered step on bit 0, N=4
    in_raw = 8'h00;
    repeat (6) tick("settle");
    filt_len = 4'd4; filt_en = 8'h01; in_raw = 8'h01;
    for (int t = 1; t <= 8; t++) begin
      tick("step");
      check("step_rise0", {7'b0, rise[0]}, {7'b0, t == 7});
      check("step_filt0", {7'b0, in_filt[0]}, {7'b0, t >= 7});
    end

    // Glitch rejection: 4-cycle pulse vanishes, 5-cycle pulse passes
    in_raw = 8'h00;
    repeat (10) tick("glitch_settle");
    flag_clr = 8'hFF;
    tick("glitch_clr");
    flag_clr = 8'h00;
    in_raw = 8'h01;
    for (int t = 1; t <= 12; t++) begin
      tick("glitch4");
      if (t == 4) in_raw = 8'h00;
      check("glitch4_filt0", {7'b0, in_filt[0]}, 8'h00);
    end
    check("glitch4_flag0", {7'b0, edge_flag[0]}, 8'h00);
    in_raw = 8'h01;
    for (int t = 1; t <= 14; t++) begin
      tick("pulse5");
      if (t == 5) in_raw = 8'h00;
      check("pulse5_rise0", {7'b0, rise[0]}, {7'b0, t == 7});
      check("pulse5_fall0", {7'b0, fall[0]}, {7'b0, t == 12});
    end

    // Bypass: 1-cycle pulse on bit 3
    filt_en = 8'h00;
    in_raw = 8'h08;
    for (int t = 1; t <= 6; t++) begin
      tick("bypass");
      if (t == 1) in_raw = 8'h00;
      check("bypass_filt3", {7'b0, in_filt[3]}, {7'b0, t == 3});
      check("bypass_rise3", {7'b0, rise[3]}, {7'b0, t == 3});
      check("bypass_fall3", {7'b0, fall[3]}, {7'b0, t == 4});
    end

    // Sticky flags and irq
    flag_clr = 8'hFF;
    tick("irq_clr_all");
    flag_clr = 8'h00; irq_mask = 8'h04; in_raw = 8'h04;
    repeat (3) tick("irq_edge2");
    check("irq_flag2", edge_flag, 8'h04);
    check("irq_set", {7'b0, irq}, 8'h01);
    flag_clr = 8'h04;
    tick("irq_clr2");
    flag_clr = 8'h00;
    check("irq_flag2_clr", edge_flag, 8'h00);
    check("irq_dropped", {7'b0, irq}, 8'h00);
    in_raw = 8'h06;
    repeat (3) tick("irq_edge1");
    check("irq_flag1", edge_flag, 8'h02);
    check("irq_unmasked", {7'b0, irq}, 8'h00);

    // Clear colliding with a new fall on bit 5
    irq_mask = 8'h20; in_raw = 8'h26;
    repeat (4) tick("coll_rise");
    in_raw = 8'h06;
    repeat (2) tick("coll_wait");
    flag_clr = 8'h20;
    tick("coll_fall");
    flag_clr = 8'h00;
    check("coll_fall5", fall, 8'h20);
    check("coll_flag5", {7'b0, edge_flag[5]}, 8'h01);
    check("coll_irq", {7'b0, irq}, 8'h01);

    // Random traffic, with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      flip = '0;
      for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(5) == 0);
      in_raw   = in_raw ^ flip;
      flag_clr = ($urandom_range(7) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(40) == 0) filt_len = 4'($urandom);
      if ($urandom_range(60) == 0) filt_en = 8'($urandom);
      if ($urandom_range(80) == 0) irq_mask = 8'($urandom);
      if (n == 1500) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rand_async_rst");
        tick("rand_rst");
        rst = 1'b0;
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
